// File: rtl/rf_commit_sequencer.sv
// Commit sequencer between the ROB commit interface and the register file.
// Buffers retired results in a small FIFO and drains one write per cycle.
// After an exception it drains the older buffered commits, then clears all
// rename tags in groups while stalling the decoder.
// Optional feature macro: RF_BYPASS_EN (adds a youngest-match FIFO bypass search).
module rf_commit_sequencer #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned REG_COUNT    = 32,
  parameter int unsigned FLUSH_STRIDE = 8,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned PC_W         = 32,
  parameter int unsigned RD_W         = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit_valid,
  output logic              commit_ready,
  input  logic [RD_W-1:0]   commit_rd,
  input  logic [DATA_W-1:0] commit_data,
  input  logic [PC_W-1:0]   commit_pc,
  input  logic              exception_in,
  output logic              wr_en,
  output logic [RD_W-1:0]   wr_rd,
  output logic [DATA_W-1:0] wr_data,
  output logic [PC_W-1:0]   wr_pc,
  output logic              tag_clr_en,
  output logic [RD_W-1:0]   tag_clr_base,
  output logic              decoder_stall,
  output logic              flush_done,
`ifdef RF_BYPASS_EN
  input  logic [RD_W-1:0]   byp_rs,
  output logic              byp_hit,
  output logic [DATA_W-1:0] byp_data,
`endif
  output logic              busy
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned NGRP  = REG_COUNT / FLUSH_STRIDE;
  localparam int unsigned GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0]   pc;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_PRE_FLUSH, S_FLUSH, S_DONE
  } state_e;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wptr_q, rptr_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  state_e             state_q, state_d;
  logic [GRP_W-1:0]   grp_q, grp_d;
  logic               init_q;
  logic               wr_en_q, tag_clr_en_q, decoder_stall_q, flush_done_q, busy_q;
  logic [RD_W-1:0]    wr_rd_q, tag_clr_base_q;
  logic [DATA_W-1:0]  wr_data_q;
  logic [PC_W-1:0]    wr_pc_q;
  logic               full, empty, accepting, push, pop;
  entry_t             head;

  // Handshake and FIFO occupancy decode from registered state only
  always_comb begin
    full         = (cnt_q == CNT_W'(DEPTH));
    empty        = (cnt_q == '0);
    accepting    = (state_q == S_IDLE) || (state_q == S_RUN);
    commit_ready = init_q && !full && accepting;
    push         = commit_valid && commit_ready;
    pop          = !empty && (accepting || (state_q == S_PRE_FLUSH));
    head         = mem_q[rptr_q];
    cnt_d        = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
  end

  // Next-state logic: drain, pre-flush drain, grouped tag clear, done pulse
  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (exception_in)       state_d = S_PRE_FLUSH;
        else if (cnt_d == '0)   state_d = S_IDLE;
        else                    state_d = S_RUN;
      end
      S_PRE_FLUSH: begin
        if (empty) begin
          state_d = S_FLUSH;
          grp_d   = '0;
        end
      end
      S_FLUSH: begin
        if (grp_q == GRP_W'(NGRP - 1)) state_d = S_DONE;
        else                           grp_d   = grp_q + GRP_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= '{rd: commit_rd, data: commit_data, pc: commit_pc};
  end

  // State, pointers and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      wptr_q          <= '0;
      rptr_q          <= '0;
      cnt_q           <= '0;
      grp_q           <= '0;
      init_q          <= 1'b0;
      wr_en_q         <= 1'b0;
      wr_rd_q         <= '0;
      wr_data_q       <= '0;
      wr_pc_q         <= '0;
      tag_clr_en_q    <= 1'b0;
      tag_clr_base_q  <= '0;
      decoder_stall_q <= 1'b0;
      flush_done_q    <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grp_q   <= grp_d;
      init_q  <= 1'b1;
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop) begin
        rptr_q    <= rptr_q + PTR_W'(1);
        wr_rd_q   <= head.rd;
        wr_data_q <= head.data;
        wr_pc_q   <= head.pc;
      end
      wr_en_q         <= pop && (head.rd != '0);
      tag_clr_en_q    <= (state_d == S_FLUSH);
      tag_clr_base_q  <= (state_d == S_FLUSH) ? RD_W'(32'(grp_d) * FLUSH_STRIDE) : '0;
      decoder_stall_q <= (state_d == S_PRE_FLUSH) || (state_d == S_FLUSH) || (state_d == S_DONE);
      flush_done_q    <= (state_d == S_DONE);
      busy_q          <= (cnt_d != '0) || (state_d != S_IDLE);
    end
  end

  assign wr_en         = wr_en_q;
  assign wr_rd         = wr_rd_q;
  assign wr_data       = wr_data_q;
  assign wr_pc         = wr_pc_q;
  assign tag_clr_en    = tag_clr_en_q;
  assign tag_clr_base  = tag_clr_base_q;
  assign decoder_stall = decoder_stall_q;
  assign flush_done    = flush_done_q;
  assign busy          = busy_q;

`ifdef RF_BYPASS_EN
  logic [PTR_W-1:0] byp_idx;

  // Youngest valid FIFO entry matching byp_rs wins (later iterations are younger)
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    byp_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      byp_idx = rptr_q + PTR_W'(i);
      if ((CNT_W'(i) < cnt_q) && (byp_rs != '0) && (mem_q[byp_idx].rd == byp_rs)) begin
        byp_hit  = 1'b1;
        byp_data = mem_q[byp_idx].data;
      end
    end
    if ((state_q == S_FLUSH) || (state_q == S_DONE)) begin
      byp_hit  = 1'b0;
      byp_data = '0;
    end
  end
`endif

endmodule

// File: tb/tb_rf_commit_sequencer.sv
// Directed self-checking bench for rf_commit_sequencer (default parameters).
module tb_rf_commit_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid, commit_ready;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data, commit_pc;
  logic        exception_in;
  logic        wr_en;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data, wr_pc;
  logic        tag_clr_en;
  logic [4:0]  tag_clr_base;
  logic        decoder_stall, flush_done, busy;
`ifdef RF_BYPASS_EN
  logic [4:0]  byp_rs;
  logic        byp_hit;
  logic [31:0] byp_data;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rf_commit_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .commit_valid  (commit_valid),
    .commit_ready  (commit_ready),
    .commit_rd     (commit_rd),
    .commit_data   (commit_data),
    .commit_pc     (commit_pc),
    .exception_in  (exception_in),
    .wr_en         (wr_en),
    .wr_rd         (wr_rd),
    .wr_data       (wr_data),
    .wr_pc         (wr_pc),
    .tag_clr_en    (tag_clr_en),
    .tag_clr_base  (tag_clr_base),
    .decoder_stall (decoder_stall),
    .flush_done    (flush_done),
`ifdef RF_BYPASS_EN
    .byp_rs        (byp_rs),
    .byp_hit       (byp_hit),
    .byp_data      (byp_data),
`endif
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d,
                       input logic [31:0] pc, input logic exc);
    commit_valid = v;
    commit_rd    = rd;
    commit_data  = d;
    commit_pc    = pc;
    exception_in = exc;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
`ifdef RF_BYPASS_EN
    byp_rs = 5'd0;
`endif
    #12;
    // Reset state
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ready", 64'(commit_ready), 64'(0));
    chk("rst_stall", 64'(decoder_stall), 64'(0));
    chk("rst_clr", 64'(tag_clr_en), 64'(0));
    chk("rst_wr_data", 64'(wr_data), 64'(0));
    chk("rst_base", 64'(tag_clr_base), 64'(0));
    @(posedge clk); #1 rst = 1'b1;
    chk("ready_wait", 64'(commit_ready), 64'(0));
    step();
    chk("ready_up", 64'(commit_ready), 64'(1));

    // Single commit, one-cycle latency
    drive(1'b1, 5'd5, 32'hDEADBEEF, 32'h1004, 1'b0);
    step();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    chk("t1_wr_en_early", 64'(wr_en), 64'(0));
    chk("t1_busy", 64'(busy), 64'(1));
    step();
    chk("t1_wr_en", 64'(wr_en), 64'(1));
    chk("t1_wr_rd", 64'(wr_rd), 64'(5));
    chk("t1_wr_data", 64'(wr_data), 64'hDEADBEEF);
    chk("t1_wr_pc", 64'(wr_pc), 64'h1004);
    step();
    chk("t1_wr_en_off", 64'(wr_en), 64'(0));
    chk("t1_busy_off", 64'(busy), 64'(0));

    // Six back-to-back commits, drained in order at one per cycle
    for (int i = 1; i <= 7; i++) begin
      if (i <= 6) begin
        drive(1'b1, 5'(i), 32'h100 + 32'(i), 32'h2000 + 32'(4 * i), 1'b0);
        chk($sformatf("t2_ready_%0d", i), 64'(commit_ready), 64'(1));
      end else begin
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
      end
      step();
      if (i >= 2) begin
        chk($sformatf("t2_wr_en_%0d", i - 1), 64'(wr_en), 64'(1));
        chk($sformatf("t2_wr_rd_%0d", i - 1), 64'(wr_rd), 64'(i - 1));
        chk($sformatf("t2_wr_data_%0d", i - 1), 64'(wr_data), 64'h100 + 64'(i - 1));
      end
    end
    step();
    chk("t2_idle", 64'(busy), 64'(0));

    // rd==0 commit is popped without a write strobe
    drive(1'b1, 5'd0, 32'h55, 32'h40, 1'b0);
    step();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    chk("t3_busy", 64'(busy), 64'(1));
    step();
    chk("t3_wr_en", 64'(wr_en), 64'(0));
    chk("t3_popped", 64'(busy), 64'(0));

    // Exception together with a 4th commit: drain, then grouped tag clear
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(6 + i), 32'hA0 + 32'(i), 32'h3000 + 32'(i), 1'b0);
      step();
    end
    drive(1'b1, 5'd9, 32'hA9, 32'h3009, 1'b1);
    chk("t4_ready_exc", 64'(commit_ready), 64'(1));
    step();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    chk("t4_wr_rd8", 64'(wr_rd), 64'(8));
    chk("t4_wr_en8", 64'(wr_en), 64'(1));
    chk("t4_ready_low", 64'(commit_ready), 64'(0));
    chk("t4_stall", 64'(decoder_stall), 64'(1));
    step();
    chk("t4_wr_en9", 64'(wr_en), 64'(1));
    chk("t4_wr_rd9", 64'(wr_rd), 64'(9));
    chk("t4_wr_data9", 64'(wr_data), 64'hA9);
    chk("t4_clr_pre", 64'(tag_clr_en), 64'(0));
    for (int g = 0; g < 4; g++) begin
      step();
      chk($sformatf("t4_clr_en_%0d", g), 64'(tag_clr_en), 64'(1));
      chk($sformatf("t4_base_%0d", g), 64'(tag_clr_base), 64'(8 * g));
      chk($sformatf("t4_wr_off_%0d", g), 64'(wr_en), 64'(0));
      chk($sformatf("t4_stall_%0d", g), 64'(decoder_stall), 64'(1));
      chk($sformatf("t4_ready_%0d", g), 64'(commit_ready), 64'(0));
    end
    step();
    chk("t4_done", 64'(flush_done), 64'(1));
    chk("t4_done_stall", 64'(decoder_stall), 64'(1));
    chk("t4_done_clr", 64'(tag_clr_en), 64'(0));
    step();
    chk("t4_done_off", 64'(flush_done), 64'(0));
    chk("t4_stall_off", 64'(decoder_stall), 64'(0));
    chk("t4_ready_back", 64'(commit_ready), 64'(1));
    chk("t4_busy_off", 64'(busy), 64'(0));

    // Exception with empty FIFO, reset asserted in 2nd tag-clear cycle
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    step();
    exception_in = 1'b0;
    chk("t5_stall", 64'(decoder_stall), 64'(1));
    chk("t5_no_clr", 64'(tag_clr_en), 64'(0));
    step();
    chk("t5_clr0", 64'(tag_clr_en), 64'(1));
    step();
    chk("t5_base1", 64'(tag_clr_base), 64'(8));
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_clr", 64'(tag_clr_en), 64'(0));
    chk("t5_rst_base", 64'(tag_clr_base), 64'(0));
    chk("t5_rst_stall", 64'(decoder_stall), 64'(0));
    chk("t5_rst_busy", 64'(busy), 64'(0));
    chk("t5_rst_ready", 64'(commit_ready), 64'(0));
    chk("t5_rst_wr_rd", 64'(wr_rd), 64'(0));
    chk("t5_rst_wr_pc", 64'(wr_pc), 64'(0));
    @(posedge clk); #1 rst = 1'b1;
    step();
    chk("t5_ready", 64'(commit_ready), 64'(1));
    drive(1'b1, 5'd3, 32'hA5A5, 32'h3000, 1'b0);
    step();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    step();
    chk("t5_wr_en", 64'(wr_en), 64'(1));
    chk("t5_wr_rd", 64'(wr_rd), 64'(3));
    chk("t5_wr_data", 64'(wr_data), 64'hA5A5);
    chk("t5_flush_done", 64'(flush_done), 64'(0));

`ifdef RF_BYPASS_EN
    // Bypass search over FIFO contents
    drive(1'b1, 5'd7, 32'h11, 32'h10, 1'b0);
    step();
    drive(1'b1, 5'd7, 32'h22, 32'h14, 1'b0);
    step();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    byp_rs = 5'd7;
    #1;
    chk("byp_hit7", 64'(byp_hit), 64'(1));
    chk("byp_data7", 64'(byp_data), 64'h22);
    byp_rs = 5'd3;
    #1;
    chk("byp_hit3", 64'(byp_hit), 64'(0));
    step();
    byp_rs = 5'd7;
    #1;
    chk("byp_drained", 64'(byp_hit), 64'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
